// File: rtl/sdram_arb_pkg.sv
// Shared types and the slot priority encoder for the SDRAM slot arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic [1:0] {SRC_BOOT, SRC_CPU, SRC_AUX} arb_src_t;

    // Boot always wins; a starved aux jumps ahead of the CPU.
    function automatic arb_src_t prio_encode(
        input logic boot_v,
        input logic cpu_r,
        input logic aux_r,
        input logic aux_starved
    );
        if (boot_v) begin
            return SRC_BOOT;
        end else if (aux_r && aux_starved) begin
            return SRC_AUX;
        end else if (cpu_r) begin
            return SRC_CPU;
        end else if (aux_r) begin
            return SRC_AUX;
        end else begin
            return SRC_CPU;
        end
    endfunction

endpackage

// File: rtl/arb_boot_buffer.sv
// One-entry holding slot for pulse-based boot ROM writes, with a sticky overflow flag.
module arb_boot_buffer #(
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [ADDR_W-1:0] a,
    input  logic [7:0]        d,
    input  logic              clr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              ovf
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              ovf_q, ovf_d;

    // Capture logic: a clear in the same cycle frees the entry for the new write.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (clr) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (wr) begin
            if (clr || !valid_q) begin
                valid_d = 1'b1;
                addr_d  = a;
                data_d  = d;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Grants one zsdram byte access per clkref slot among boot, CPU and aux requesters.
// Optional grant statistics (stat_sel/stat_q ports) are built when ARB_STATS_EN is defined.
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int DONE_CYC   = 20,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_sys,
    input  logic              RESET_n,
    input  logic              clkref,
    input  logic              boot_wr,
    input  logic [ADDR_W-1:0] boot_a,
    input  logic [7:0]        boot_d,
    output logic              boot_ovf,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_d,
    output logic              cpu_ack,
    output logic [7:0]        cpu_q,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_a,
    input  logic [7:0]        aux_d,
    output logic              aux_ack,
    output logic [7:0]        aux_q,
    output logic              sd_oe,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    input  logic [7:0]        sd_dout,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    input  logic [1:0]        stat_sel,
    output logic [15:0]       stat_q
`endif
);

    localparam int CNT_W = $clog2(DONE_CYC);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    arb_src_t          src_q, src_d, winner_s;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              sd_oe_q, sd_oe_d, sd_we_q, sd_we_d, busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d, aux_ack_q, aux_ack_d;
    logic [7:0]        cpu_rd_q, cpu_rd_d, aux_rd_q, aux_rd_d;
    logic              boot_valid_s, boot_clr_s, grant_s;
    logic [ADDR_W-1:0] boot_addr_s, sel_addr_s;
    logic [7:0]        boot_data_s, sel_data_s;
    logic              sel_we_s;

    arb_boot_buffer #(.ADDR_W(ADDR_W)) u_boot_buf (
        .clk   (clk_sys),
        .rst_n (RESET_n),
        .wr    (boot_wr),
        .a     (boot_a),
        .d     (boot_d),
        .clr   (boot_clr_s),
        .valid (boot_valid_s),
        .addr  (boot_addr_s),
        .data  (boot_data_s),
        .ovf   (boot_ovf)
    );

    assign winner_s = prio_encode(boot_valid_s, cpu_req, aux_req,
                                  starve_q == SW'(STARVE_MAX));
    assign grant_s  = (state_q == IDLE) && clkref && (boot_valid_s || cpu_req || aux_req);

    // Route the winning requester's access fields.
    always_comb begin
        sel_we_s   = 1'b1;
        sel_addr_s = boot_addr_s;
        sel_data_s = boot_data_s;
        case (winner_s)
            SRC_BOOT: begin
                sel_we_s   = 1'b1;
                sel_addr_s = boot_addr_s;
                sel_data_s = boot_data_s;
            end
            SRC_AUX: begin
                sel_we_s   = aux_we;
                sel_addr_s = aux_a;
                sel_data_s = aux_d;
            end
            default: begin
                sel_we_s   = cpu_we;
                sel_addr_s = cpu_a;
                sel_data_s = cpu_d;
            end
        endcase
    end

    // Slot FSM: next state, latched access and registered SDRAM/ack outputs.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        sd_oe_d    = sd_oe_q;
        sd_we_d    = sd_we_q;
        busy_d     = busy_q;
        cpu_ack_d  = 1'b0;
        aux_ack_d  = 1'b0;
        cpu_rd_d   = cpu_rd_q;
        aux_rd_d   = aux_rd_q;
        boot_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = ISSUE;
                    src_d   = winner_s;
                    we_d    = sel_we_s;
                    addr_d  = sel_addr_s;
                    data_d  = sel_data_s;
                    sd_we_d = sel_we_s;
                    sd_oe_d = ~sel_we_s;
                    busy_d  = 1'b1;
                    if (winner_s == SRC_AUX) begin
                        starve_d = {SW{1'b0}};
                    end else if (winner_s == SRC_CPU && aux_req && starve_q != SW'(STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                boot_clr_s = (src_q == SRC_BOOT);
                cnt_d      = CNT_W'(DONE_CYC - 2);
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d   = DONE;
                    sd_oe_d   = 1'b0;
                    sd_we_d   = 1'b0;
                    cpu_ack_d = (src_q == SRC_CPU);
                    aux_ack_d = (src_q == SRC_AUX);
                    if (!we_q && src_q == SRC_CPU) begin
                        cpu_rd_d = sd_dout;
                    end else if (!we_q && src_q == SRC_AUX) begin
                        aux_rd_d = sd_dout;
                    end else begin
                        cpu_rd_d = cpu_rd_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers; reset abandons any access in flight.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            src_q     <= SRC_BOOT;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            data_q    <= 8'h00;
            cnt_q     <= {CNT_W{1'b0}};
            starve_q  <= {SW{1'b0}};
            sd_oe_q   <= 1'b0;
            sd_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            cpu_ack_q <= 1'b0;
            aux_ack_q <= 1'b0;
            cpu_rd_q  <= 8'h00;
            aux_rd_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            sd_oe_q   <= sd_oe_d;
            sd_we_q   <= sd_we_d;
            busy_q    <= busy_d;
            cpu_ack_q <= cpu_ack_d;
            aux_ack_q <= aux_ack_d;
            cpu_rd_q  <= cpu_rd_d;
            aux_rd_q  <= aux_rd_d;
        end
    end

    assign sd_oe   = sd_oe_q;
    assign sd_we   = sd_we_q;
    assign sd_addr = addr_q;
    assign sd_din  = data_q;
    assign busy    = busy_q;
    assign cpu_ack = cpu_ack_q;
    assign aux_ack = aux_ack_q;
    assign cpu_q   = cpu_rd_q;
    assign aux_q   = aux_rd_q;

`ifdef ARB_STATS_EN
    logic [15:0]   cnt_boot_q, cnt_boot_d, cnt_cpu_q, cnt_cpu_d, cnt_aux_q, cnt_aux_d;
    logic [15:0]   stat_q_q, stat_q_d;
    logic [SW-1:0] peak_q, peak_d;

    // Grant counters, peak starvation and the readback mux.
    always_comb begin
        cnt_boot_d = cnt_boot_q;
        cnt_cpu_d  = cnt_cpu_q;
        cnt_aux_d  = cnt_aux_q;
        if (grant_s) begin
            case (winner_s)
                SRC_BOOT: cnt_boot_d = cnt_boot_q + 16'd1;
                SRC_AUX:  cnt_aux_d  = cnt_aux_q + 16'd1;
                default:  cnt_cpu_d  = cnt_cpu_q + 16'd1;
            endcase
        end else begin
            cnt_boot_d = cnt_boot_q;
        end
        peak_d = (starve_d > peak_q) ? starve_d : peak_q;
        case (stat_sel)
            2'd0:    stat_q_d = cnt_boot_q;
            2'd1:    stat_q_d = cnt_cpu_q;
            2'd2:    stat_q_d = cnt_aux_q;
            default: stat_q_d = {{(16 - SW){1'b0}}, peak_q};
        endcase
    end

    // Statistics registers.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_boot_q <= 16'h0000;
            cnt_cpu_q  <= 16'h0000;
            cnt_aux_q  <= 16'h0000;
            peak_q     <= {SW{1'b0}};
            stat_q_q   <= 16'h0000;
        end else begin
            cnt_boot_q <= cnt_boot_d;
            cnt_cpu_q  <= cnt_cpu_d;
            cnt_aux_q  <= cnt_aux_d;
            peak_q     <= peak_d;
            stat_q_q   <= stat_q_d;
        end
    end

    assign stat_q = stat_q_q;
`endif

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Randomized self-checking bench for sdram_slot_arbiter against a slot-level reference model.
module tb_sdram_slot_arbiter;

    localparam int AW = 23;
    localparam int DC = 20;
    localparam int SM = 3;

    logic          clk_sys = 1'b0;
    logic          RESET_n, clkref, boot_wr, boot_ovf;
    logic [AW-1:0] boot_a, cpu_a, aux_a, sd_addr;
    logic [7:0]    boot_d, cpu_d, aux_d, cpu_q, aux_q, sd_din, sd_dout;
    logic          cpu_req, cpu_we, cpu_ack, aux_req, aux_we, aux_ack;
    logic          sd_oe, sd_we, busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: transaction level, one entry per requester.
    logic          m_bv, m_ovf;
    logic [AW-1:0] m_ba;
    logic [7:0]    m_bd, m_cpu_q, m_aux_q;
    int            m_starve;
    logic          m_cpu_pend, m_aux_pend;

    always #5 clk_sys = ~clk_sys;

    sdram_slot_arbiter #(.ADDR_W(AW), .DONE_CYC(DC), .STARVE_MAX(SM)) dut (
        .clk_sys (clk_sys), .RESET_n (RESET_n), .clkref (clkref),
        .boot_wr (boot_wr), .boot_a (boot_a), .boot_d (boot_d), .boot_ovf (boot_ovf),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_a (cpu_a), .cpu_d (cpu_d),
        .cpu_ack (cpu_ack), .cpu_q (cpu_q),
        .aux_req (aux_req), .aux_we (aux_we), .aux_a (aux_a), .aux_d (aux_d),
        .aux_ack (aux_ack), .aux_q (aux_q),
        .sd_oe (sd_oe), .sd_we (sd_we), .sd_addr (sd_addr), .sd_din (sd_din),
        .sd_dout (sd_dout), .busy (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic model_reset();
        m_bv = 1'b0; m_ovf = 1'b0; m_ba = '0; m_bd = 8'h00;
        m_cpu_q = 8'h00; m_aux_q = 8'h00; m_starve = 0;
        m_cpu_pend = 1'b0; m_aux_pend = 1'b0;
        cpu_req = 1'b0; aux_req = 1'b0;
    endtask

    task automatic boot_write(input logic [AW-1:0] a, input logic [7:0] d);
        boot_a = a; boot_d = d; boot_wr = 1'b1;
        tick();
        boot_wr = 1'b0;
        if (m_bv) begin
            m_ovf = 1'b1;
        end else begin
            m_bv = 1'b1; m_ba = a; m_bd = d;
        end
    endtask

    task automatic cpu_request(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_we = we; cpu_a = a; cpu_d = d; cpu_req = 1'b1; m_cpu_pend = 1'b1;
    endtask

    task automatic aux_request(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        aux_we = we; aux_a = a; aux_d = d; aux_req = 1'b1; m_aux_pend = 1'b1;
    endtask

    // One clkref slot: predict the winner, then check issue, hold, ack and idle.
    task automatic run_slot(output int obs);
        int            win;
        logic          ew, b1;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        if (m_bv)                               win = 1;
        else if (m_aux_pend && m_starve == SM)  win = 3;
        else if (m_cpu_pend)                    win = 2;
        else if (m_aux_pend)                    win = 3;
        else                                    win = 0;
        ew = 1'b1; ea = m_ba; ed = m_bd;
        if (win == 2) begin ew = cpu_we; ea = cpu_a; ed = cpu_d; end
        if (win == 3) begin ew = aux_we; ea = aux_a; ed = aux_d; end
        if (win == 3) m_starve = 0;
        else if (win == 2 && m_aux_pend && m_starve < SM) m_starve++;
        if (win == 1) m_bv = 1'b0;

        clkref = 1'b1;
        tick();
        clkref = 1'b0;
        b1 = busy;
        check_eq("issue_busy", {31'd0, busy}, {31'd0, win != 0});
        check_eq("issue_we", {31'd0, sd_we}, {31'd0, (win != 0) && ew});
        check_eq("issue_oe", {31'd0, sd_oe}, {31'd0, (win != 0) && !ew});
        if (win != 0) begin
            check_eq("issue_addr", {9'd0, sd_addr}, {9'd0, ea});
            check_eq("issue_din", {24'd0, sd_din}, {24'd0, ed});
        end
        repeat (DC - 1) tick();
        check_eq("hold_oe", {31'd0, sd_oe}, {31'd0, (win != 0) && !ew});
        check_eq("hold_we", {31'd0, sd_we}, {31'd0, (win != 0) && ew});
        if (win != 0) check_eq("hold_addr", {9'd0, sd_addr}, {9'd0, ea});
        check_eq("early_ack", {30'd0, cpu_ack, aux_ack}, 32'd0);

        tick();
        if (win == 2 && !ew) m_cpu_q = sd_dout;
        if (win == 3 && !ew) m_aux_q = sd_dout;
        check_eq("cpu_ack", {31'd0, cpu_ack}, {31'd0, win == 2});
        check_eq("aux_ack", {31'd0, aux_ack}, {31'd0, win == 3});
        check_eq("cpu_q", {24'd0, cpu_q}, {24'd0, m_cpu_q});
        check_eq("aux_q", {24'd0, aux_q}, {24'd0, m_aux_q});
        check_eq("done_oe_we", {30'd0, sd_oe, sd_we}, 32'd0);
        check_eq("done_busy", {31'd0, busy}, {31'd0, win != 0});
        obs = cpu_ack ? 2 : (aux_ack ? 3 : (b1 ? 1 : 0));
        if (win == 2) begin m_cpu_pend = 1'b0; cpu_req = 1'b0; end
        if (win == 3) begin m_aux_pend = 1'b0; aux_req = 1'b0; end

        tick();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_ack", {30'd0, cpu_ack, aux_ack}, 32'd0);
        check_eq("boot_ovf", {31'd0, boot_ovf}, {31'd0, m_ovf});
    endtask

    initial begin
        int obs;
        int acks;
        int pat [8] = '{2, 2, 2, 3, 2, 2, 2, 3};
        RESET_n = 1'b0; clkref = 1'b0; boot_wr = 1'b0; boot_a = '0; boot_d = 8'h00;
        cpu_we = 1'b0; cpu_a = '0; cpu_d = 8'h00; aux_we = 1'b0; aux_a = '0; aux_d = 8'h00;
        sd_dout = 8'h00;
        model_reset();
        repeat (3) tick();
        check_eq("rst_outs", {25'd0, sd_oe, sd_we, busy, cpu_ack, aux_ack, boot_ovf, 1'b0},
                 32'd0);
        check_eq("rst_addr", {9'd0, sd_addr}, 32'd0);
        check_eq("rst_q", {16'd0, cpu_q, aux_q}, 32'd0);
        RESET_n = 1'b1;
        repeat (2) tick();

        // Boot only
        boot_write(23'h000123, 8'h5A);
        tick();
        run_slot(obs);
        check_eq("boot_only_win", obs, 1);
        run_slot(obs);
        check_eq("boot_emptied", obs, 0);

        // CPU read
        cpu_request(1'b0, 23'h010000, 8'h00);
        sd_dout = 8'hC3;
        run_slot(obs);
        check_eq("cpu_read_win", obs, 2);
        check_eq("cpu_read_q", {24'd0, cpu_q}, 32'h0000_00C3);

        // Boot vs CPU
        boot_write(23'h0000AA, 8'h11);
        cpu_request(1'b1, 23'h000BBB, 8'h22);
        run_slot(obs);
        check_eq("bvc_first", obs, 1);
        run_slot(obs);
        check_eq("bvc_second", obs, 2);

        // Starvation pattern with both requesters held
        for (int i = 0; i < 8; i++) begin
            if (!m_cpu_pend) cpu_request(1'b0, AW'($urandom), 8'($urandom));
            if (!m_aux_pend) aux_request(1'b0, AW'($urandom), 8'($urandom));
            sd_dout = 8'($urandom);
            tick();
            run_slot(obs);
            check_eq("starve_order", obs, pat[i]);
        end
        cpu_req = 1'b0; aux_req = 1'b0; m_cpu_pend = 1'b0; m_aux_pend = 1'b0;
        m_starve = 0;
        tick();

        // Overflow
        boot_write(23'h000200, 8'h33);
        boot_write(23'h000201, 8'h44);
        check_eq("ovf_set", {31'd0, boot_ovf}, 32'd1);
        run_slot(obs);
        check_eq("ovf_first", obs, 1);
        run_slot(obs);
        check_eq("ovf_second_lost", obs, 0);

        // Randomized slots
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3, 0) == 0) boot_write(AW'($urandom), 8'($urandom));
            if ($urandom_range(15, 0) == 0) boot_write(AW'($urandom), 8'($urandom));
            if (!m_cpu_pend && $urandom_range(1, 0) == 1)
                cpu_request(1'($urandom), AW'($urandom), 8'($urandom));
            if (!m_aux_pend && $urandom_range(1, 0) == 1)
                aux_request(1'($urandom), AW'($urandom), 8'($urandom));
            sd_dout = 8'($urandom);
            tick();
            run_slot(obs);
        end

        // Reset mid-WAIT
        cpu_request(1'b0, 23'h012345, 8'h00);
        sd_dout = 8'h77;
        clkref = 1'b1;
        tick();
        clkref = 1'b0;
        repeat (5) tick();
        RESET_n = 1'b0;
        #1;
        check_eq("midrst_outs", {29'd0, sd_oe, sd_we, busy}, 32'd0);
        check_eq("midrst_ovf", {31'd0, boot_ovf}, 32'd0);
        model_reset();
        repeat (3) tick();
        RESET_n = 1'b1;
        acks = 0;
        for (int i = 0; i < DC + 5; i++) begin
            tick();
            if (cpu_ack || aux_ack) acks++;
        end
        check_eq("midrst_no_ack", acks, 0);
        cpu_request(1'b0, 23'h054321, 8'h00);
        sd_dout = 8'h9E;
        run_slot(obs);
        check_eq("post_rst_win", obs, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_slot_arbiter.md
Name: sdram_slot_arbiter

Overview:
- Shares the single zsdram byte port between three requesters:
  - boot loader: ioctl ROM writes, pulse-based;
  - CPU/motherboard: ram_R/ram_W;
  - aux DMA requester: snapshot/tape loader.
- Grants at most one access per clkref slot and sequences oe/we/addr/din toward the SDRAM controller.
- Returns read data with a one-cycle ack.
- Replaces the reset-based static mux in front of zsdram.

Parameters:
- ADDR_W, 23, byte address width toward SDRAM.
- DONE_CYC, 20, clk_sys cycles from issue until SDRAM dout is valid (must be < slot length).
- STARVE_MAX, 3, consecutive slots aux may lose to CPU before it gets priority.

Ports:
- clk_sys  in  1  system clock (all logic on posedge).
- RESET_n  in  1  asynchronous, active-low reset.
- clkref  in  1  slot strobe, one clk_sys cycle wide, once per slot.
- boot_wr  in  1  one-cycle boot write pulse.
- boot_a  in  ADDR_W  boot write address, sampled on boot_wr.
- boot_d  in  8  boot write data, sampled on boot_wr.
- boot_ovf  out  1  sticky: a boot_wr arrived while the boot buffer was full.
- cpu_req  in  1  CPU request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_a  in  ADDR_W  CPU address.
- cpu_d  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_q  out  8  CPU read data, valid with cpu_ack, then held.
- aux_req, aux_we, aux_a, aux_d, aux_ack, aux_q: same as the cpu_* set.
- sd_oe  out  1  to zsdram oe.
- sd_we  out  1  to zsdram we.
- sd_addr  out  ADDR_W  to zsdram addr.
- sd_din  out  8  to zsdram din.
- sd_dout  in  8  from zsdram dout.
- busy  out  1  high from issue until the ack cycle.

Behaviour:
- Reset values: all outputs 0. boot buffer empty, starve counter 0, state IDLE.
- Boot buffer: one entry (valid, addr, data).
  - boot_wr with buffer empty: capture addr/data, set valid.
  - boot_wr with buffer full: drop the write, set boot_ovf.
  - boot_ovf clears only on reset.
  - If boot_wr coincides with the buffer being granted, the new write is captured in the same cycle (grant frees the buffer first).
- State IDLE:
  - On clkref, pick a winner from requests pending in that cycle.
  - Priority: boot > aux (if starve counter == STARVE_MAX) > cpu > aux.
  - Latch winner id, we, addr, data. Go to ISSUE.
  - clkref with no request: stay IDLE.
- State ISSUE (1 cycle):
  - Drive sd_addr/sd_din.
  - Drive sd_we = latched we, sd_oe = ~latched we. Boot is always a write.
  - Clear the buffer if boot won. Load the wait counter. Go to WAIT.
- State WAIT:
  - Hold sd_* stable. Count DONE_CYC-1 cycles, then go to DONE.
  - clkref arriving during WAIT is ignored; no new grant until IDLE.
- State DONE (1 cycle):
  - Drop sd_oe/sd_we. If read, latch sd_dout into winner's *_q.
  - Pulse winner's *_ack. Go to IDLE.
  - Earliest next grant is the next clkref.
- Starve counter, updated at each grant:
  - Increments when aux_req is pending and CPU wins, saturating at STARVE_MAX.
  - Resets to 0 when aux wins.
- Requester rules:
  - Dropping req before ack is illegal; the access still completes and ack still pulses.
  - A requester may re-assert req the cycle after ack.
- Latency: issue occurs 1 cycle after clkref; ack occurs DONE_CYC+1 cycles after clkref.
- Reset mid-access: outputs clear immediately and the access is abandoned; no ack.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds three 16-bit grant counters (boot/cpu/aux), wrapping at 0xFFFF→0.
  - Adds ports stat_sel[1:0] in and stat_q[15:0] out; stat_sel 3 returns the peak starve count.
  - Counters clear on reset.
- When undefined: no counters and no stat ports; all other behaviour identical.

Decomposition:
- Package sdram_arb_pkg:
  - typedef enum {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  - typedef enum logic[1:0] {SRC_BOOT, SRC_CPU, SRC_AUX} arb_src_t;
  - priority-encode function.
- Sub-module arb_boot_buffer: the one-entry capture and overflow logic.

Test Plan:
- Boot only: boot_wr a=0x000123 d=0x5A, then clkref → sd_we=1, sd_addr=0x000123, sd_din=0x5A one cycle after clkref, held DONE_CYC cycles; buffer empties.
- CPU read: cpu_req, we=0, a=0x010000, sd_dout=0xC3 → cpu_ack exactly DONE_CYC+1 cycles after clkref, cpu_q=0xC3, sd_oe=1 during the access.
- Boot vs CPU: both pending at clkref → boot granted first; CPU granted at the next clkref.
- Starvation: cpu_req and aux_req held continuously, STARVE_MAX=3 → grant order cpu,cpu,cpu,aux,cpu,… repeating.
- Overflow: two boot_wr pulses with no clkref between → boot_ovf=1; first write performed at the next clkref, second lost.
- Reset: RESET_n low mid-WAIT → sd_oe/sd_we/busy 0 immediately; no ack; after release, the next clkref grants normally.
